uart_tx_frame_scheduler: RTL and testbench

Single-clock scheduler that sits in front of the UART transmit FIFO and shares its write port between two requesters: the control-response stream (pre-formatted 40-bit frames) and the communication data stream (32-bit words). Communication words are wrapped into 40-bit frames with a tag byte. Control frames have priority, and communication bursts are bounded by a configurable limit so control latency stays bounded. It sits in the UART clock domain, between the register/command logic and the TX FIFO feeding the UART TX protocol engine.

---
 rtl/uart_tx_frame_scheduler.sv | 123 ++++++++++++
 tb/tb_uart_tx_frame_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_scheduler.sv
// Purpose : arbitrates the UART TX FIFO write port between control frames and tagged comm frames.
// Latency : 1-cycle grant from IDLE; FIFO write registered 1 cycle after each handshake.
// Backpres: Fifo_Full drops both readies combinationally; comm bursts yield to control every BURST_MAX frames.
//
// Ports:
//   clk_i, rst_i                     - UART clock, synchronous active-high reset
//   ctrl_valid_i/ctrl_data_i         - 40-bit pre-formatted control frames, ctrl_ready_o accepts
//   comm_valid_i/comm_data_i/        - 32-bit comm words with packet-last flag and channel,
//   comm_last_i/comm_channel_i         comm_ready_o accepts
//   fifo_full_i                      - TX FIFO full (one slot still reserved after assertion)
//   fifo_we_o/fifo_data_o            - registered TX FIFO write strobe and 40-bit frame
//   busy_o                           - scheduler not in IDLE
//   comm_frame_count_o               - wrapping count of comm frames written
module uart_tx_frame_scheduler #(
    parameter int unsigned BURST_MAX = 16,
    parameter logic [2:0]  COMM_TAG  = 3'b101
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ctrl_valid_i,
    input  logic [39:0] ctrl_data_i,
    output logic        ctrl_ready_o,
    input  logic        comm_valid_i,
    input  logic [31:0] comm_data_i,
    input  logic        comm_last_i,
    input  logic [3:0]  comm_channel_i,
    output logic        comm_ready_o,
    input  logic        fifo_full_i,
    output logic        fifo_we_o,
    output logic [39:0] fifo_data_o,
    output logic        busy_o,
    output logic [15:0] comm_frame_count_o
);

    localparam logic [7:0] BURST_LIMIT = 8'(BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CTRL = 2'd1,
        ST_COMM = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  burst_q;
    logic [7:0]  burst_d;
    logic        fifo_we_q;
    logic [39:0] fifo_data_q;
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;
    logic [39:0] comm_frame_d;
    logic        ctrl_hs;
    logic        comm_hs;
    logic        burst_hit;

    // Readies depend only on the state register and FIFO full, so at most one
    // of them can be high in any cycle.
    assign ctrl_ready_o = (state_q == ST_CTRL) && !fifo_full_i;
    assign comm_ready_o = (state_q == ST_COMM) && !fifo_full_i;

    assign ctrl_hs = ctrl_valid_i && ctrl_ready_o;
    assign comm_hs = comm_valid_i && comm_ready_o;

    assign burst_d      = burst_q + 8'd1;
    assign burst_hit    = (burst_d == BURST_LIMIT);
    assign frame_cnt_d  = frame_cnt_q + 16'd1;
    assign comm_frame_d = {COMM_TAG, comm_last_i, comm_channel_i, comm_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            burst_q     <= 8'd0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= 40'd0;
            frame_cnt_q <= 16'd0;
        end else begin
            fifo_we_q <= ctrl_hs || comm_hs;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_valid_i) begin
                        state_q <= ST_CTRL;
                    end else if (comm_valid_i) begin
                        state_q <= ST_COMM;
                        burst_q <= 8'd0;
                    end
                end
                ST_CTRL: begin
                    // One control frame per grant keeps comm starvation bounded too.
                    if (ctrl_hs) begin
                        fifo_data_q <= ctrl_data_i;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_COMM: begin
                    if (comm_hs) begin
                        fifo_data_q <= comm_frame_d;
                        frame_cnt_q <= frame_cnt_d;
                        if (comm_last_i) begin
                            state_q <= ST_IDLE;
                        end else if (burst_hit) begin
                            // Burst boundary: yield only if control is actually waiting,
                            // otherwise restart the burst and keep streaming.
                            burst_q <= 8'd0;
                            if (ctrl_valid_i) begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            burst_q <= burst_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_we_o          = fifo_we_q;
    assign fifo_data_o        = fifo_data_q;
    assign comm_frame_count_o = frame_cnt_q;
    assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_frame_scheduler.sv
// Purpose : self-checking bench for uart_tx_frame_scheduler (BURST_MAX=4).
// Latency : expects FIFO writes one cycle after each handshake, in model-predicted order.
// Backpres: drives random/directed Fifo_Full and valid gaps; checks readies drop while full.
module tb_uart_tx_frame_scheduler;

    localparam int         BM       = 4;
    localparam logic [2:0] COMM_TAG = 3'b101;

    logic        clk;
    logic        rst;
    logic        ctrl_valid;
    logic [39:0] ctrl_data;
    logic        ctrl_ready_o;
    logic        comm_valid;
    logic [31:0] comm_data;
    logic        comm_last;
    logic [3:0]  comm_channel;
    logic        comm_ready_o;
    logic        fifo_full;
    logic        fifo_we_o;
    logic [39:0] fifo_data_o;
    logic        busy_o;
    logic [15:0] comm_frame_count_o;

    uart_tx_frame_scheduler #(
        .BURST_MAX (BM),
        .COMM_TAG  (COMM_TAG)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .ctrl_valid_i       (ctrl_valid),
        .ctrl_data_i        (ctrl_data),
        .ctrl_ready_o       (ctrl_ready_o),
        .comm_valid_i       (comm_valid),
        .comm_data_i        (comm_data),
        .comm_last_i        (comm_last),
        .comm_channel_i     (comm_channel),
        .comm_ready_o       (comm_ready_o),
        .fifo_full_i        (fifo_full),
        .fifo_we_o          (fifo_we_o),
        .fifo_data_o        (fifo_data_o),
        .busy_o             (busy_o),
        .comm_frame_count_o (comm_frame_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [39:0] exp_q[$];
    logic [31:0] pkt[$];
    int          exp_frames;
    int          cyc_no      = 0;
    int          first_w;
    int          last_w;
    int          we_full_cnt;
    bit          last_hc;
    bit          last_hm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic cyc();
        bit hc;
        bit hm;
        #1;
        hc = ctrl_valid && ctrl_ready_o;
        hm = comm_valid && comm_ready_o;
        chk("ready_exclusive", {63'd0, ctrl_ready_o & comm_ready_o}, 64'd0);
        if (fifo_full) begin
            chk("ready_while_full", {63'd0, ctrl_ready_o | comm_ready_o}, 64'd0);
            if (fifo_we_o) we_full_cnt++;
        end
        @(posedge clk);
        #1;
        cyc_no++;
        last_hc = hc;
        last_hm = hm;
        chk("we_after_handshake", {63'd0, fifo_we_o}, {63'd0, hc | hm});
        if (fifo_we_o) begin
            if (first_w < 0) first_w = cyc_no;
            last_w = cyc_no;
            if (exp_q.size() == 0) chk("spurious_we", {63'd0, fifo_we_o}, 64'd0);
            else chk("wdata", {24'd0, fifo_data_o}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        ctrl_valid = 1'b0;
        comm_valid = 1'b0;
        fifo_full  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl_ready", {63'd0, ctrl_ready_o}, 64'd0);
        chk("rst_comm_ready", {63'd0, comm_ready_o}, 64'd0);
        chk("rst_fifo_we",    {63'd0, fifo_we_o},    64'd0);
        chk("rst_fifo_data",  {24'd0, fifo_data_o},  64'd0);
        chk("rst_busy",       {63'd0, busy_o},       64'd0);
        chk("rst_frame_cnt",  {48'd0, comm_frame_count_o}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        exp_frames = 0;
    endtask

    task automatic fill_random(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom);
    endtask

    // Sends one packet from pkt[] plus an optional control frame raised after
    // raise_j comm handshakes. Expected write order: the control frame lands
    // after the first comm frame whose index is a multiple of BM at or after
    // raise_j+1, or after the packet end if that comes first.
    task automatic run_packet(input int n, input logic [3:0] chan, input int raise_j,
                              input logic [39:0] cdat, input int full_prob, input int gap_prob,
                              input int full_at, input bit chk_span);
        int  sent;
        int  cycles;
        int  p;
        int  full_left;
        bit  ctrl_done;
        bit  has_ctrl;
        logic [31:0] w[$];
        w = pkt;
        exp_q.delete();
        has_ctrl = (raise_j >= 0);
        p = -1;
        if (has_ctrl) begin
            if (raise_j == 0) p = 0;
            else begin
                p = ((raise_j + BM) / BM) * BM;
                if (p > n) p = n;
            end
        end
        if (p == 0) exp_q.push_back(cdat);
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back({COMM_TAG, (k == n), chan, w[k-1]});
            if (k == p) exp_q.push_back(cdat);
        end
        sent = 0; cycles = 0; ctrl_done = 0; full_left = 5;
        first_w = -1; last_w = -1; we_full_cnt = 0;
        comm_channel = chan;
        ctrl_data    = cdat;
        while (((sent < n) || (has_ctrl && !ctrl_done) || (exp_q.size() > 0))
               && (cycles < 20 * n + 100)) begin
            comm_valid = (sent < n) && (int'($urandom_range(99)) >= gap_prob);
            comm_data  = (sent < n) ? w[sent] : 32'd0;
            comm_last  = (sent == n - 1);
            ctrl_valid = has_ctrl && !ctrl_done && (sent >= raise_j);
            fifo_full  = (int'($urandom_range(99)) < full_prob);
            if (full_at >= 0 && sent >= full_at && full_left > 0) begin
                fifo_full = 1'b1;
                full_left--;
            end
            cyc();
            if (last_hm) sent++;
            if (last_hc) ctrl_done = 1;
            cycles++;
        end
        comm_valid = 1'b0;
        ctrl_valid = 1'b0;
        fifo_full  = 1'b0;
        exp_frames += n;
        chk("words_accepted", 64'(sent), 64'(n));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
        chk("busy_after_pkt", {63'd0, busy_o}, 64'd0);
        chk("frame_count", {48'd0, comm_frame_count_o}, 64'(exp_frames & 16'hFFFF));
        if (chk_span)
            chk("write_span", 64'(last_w - first_w), 64'(n - 1 + ((full_at >= 0) ? 5 : 0)));
        if (full_at >= 0)
            chk("we_during_full", 64'(we_full_cnt), 64'd1);
    endtask

    initial begin
        logic [39:0] cd;
        int          n;
        int          j;
        rst          = 1'b1;
        ctrl_valid   = 1'b0;
        ctrl_data    = 40'd0;
        comm_valid   = 1'b0;
        comm_data    = 32'd0;
        comm_last    = 1'b0;
        comm_channel = 4'd0;
        fifo_full    = 1'b0;
        exp_frames   = 0;

        // Reset state.
        do_reset();

        // Single control frame.
        ctrl_valid = 1'b1;
        ctrl_data  = 40'h12_3456_789A;
        exp_q.push_back(40'h12_3456_789A);
        first_w = -1;
        cyc();
        chk("ctrl_ready_grant", {63'd0, ctrl_ready_o}, 64'd1);
        chk("busy_in_ctrl", {63'd0, busy_o}, 64'd1);
        cyc();
        chk("ctrl_frame_out", {24'd0, fifo_data_o}, {24'd0, 40'h12_3456_789A});
        ctrl_valid = 1'b0;
        chk("busy_after_ctrl", {63'd0, busy_o}, 64'd0);

        // Three-word communication packet on channel 5.
        pkt.delete();
        pkt.push_back(32'h1111_1111);
        pkt.push_back(32'h2222_2222);
        pkt.push_back(32'h3333_3333);
        run_packet(3, 4'h5, -1, 40'd0, 0, 0, -1, 1);
        chk("pkt3_count", {48'd0, comm_frame_count_o}, 64'd3);

        // Burst yield: control raised during word 2 of a 10-word packet.
        fill_random(10);
        run_packet(10, 4'h3, 1, 40'hC0_FFEE_0001, 0, 0, -1, 0);
        // Same packet length without control streams back-to-back.
        fill_random(10);
        run_packet(10, 4'h9, -1, 40'd0, 0, 0, -1, 1);

        // Backpressure: 5 full cycles after the third word.
        fill_random(8);
        run_packet(8, 4'h6, -1, 40'd0, 0, 0, 3, 1);

        // Simultaneous requests from IDLE: control first.
        fill_random(3);
        run_packet(3, 4'h1, 0, 40'hAB_CDEF_0123, 0, 0, -1, 0);

        // Reset mid-packet, with a live handshake in the reset cycle.
        comm_valid   = 1'b1;
        comm_last    = 1'b0;
        comm_data    = 32'hDEAD_BEEF;
        comm_channel = 4'h2;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_we",   {63'd0, fifo_we_o}, 64'd1);
        chk("pre_rst_busy", {63'd0, busy_o},    64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_fifo_we",   {63'd0, fifo_we_o},    64'd0);
        chk("midrst_fifo_data", {24'd0, fifo_data_o},  64'd0);
        chk("midrst_busy",      {63'd0, busy_o},       64'd0);
        chk("midrst_ready",     {62'd0, ctrl_ready_o, comm_ready_o}, 64'd0);
        chk("midrst_frame_cnt", {48'd0, comm_frame_count_o}, 64'd0);
        rst        = 1'b0;
        comm_valid = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        // Fresh burst count: control must follow word 4, not earlier.
        fill_random(6);
        run_packet(6, 4'hE, 1, 40'h55_AA55_AA55, 0, 0, -1, 0);

        // Randomized packets with gaps, backpressure and optional control frames.
        for (int t = 0; t < 12; t++) begin
            n = int'($urandom_range(1, 12));
            j = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(0, n));
            cd = {8'($urandom), 32'($urandom)};
            fill_random(n);
            run_packet(n, 4'($urandom_range(15)), j, cd, 25, 20, -1, 0);
        end

        // Counter wrap after 65537 frames.
        do_reset();
        fill_random(65537);
        run_packet(65537, 4'h7, -1, 40'd0, 0, 0, -1, 1);
        chk("count_wrap", {48'd0, comm_frame_count_o}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
